// File: rtl/m_ext_stage.sv
// m_ext_stage: registered M-stage extender.
// Extends immediates (sign / zero / lui placement) and load data (byte / halfword lane
// extract with sign or zero fill), or passes the word through. The result is held in a
// one-deep output register with stall / flush control. Misaligned halfword requests are
// flagged (their data is forced to zero) and counted in a saturating counter.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   in_valid  in   request present this cycle
//   stall     in   hold all outputs
//   flush     in   insert a bubble (wins over stall)
//   ext_op    in   extension mode
//   ext_in    in   immediate (low IMM_W bits) or DM read word
//   addr_lo   in   byte lane select
//   out_valid out  registered result valid
//   ext_out   out  registered extended result
//   misalign  out  registered misaligned-halfword flag
//   err_cnt   out  saturating count of accepted misaligned requests
module m_ext_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMM_W  = 16,
    parameter int unsigned LANE_W = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [2:0]        ext_op,
    input  logic [DATA_W-1:0] ext_in,
    input  logic [LANE_W-1:0] addr_lo,
    output logic              out_valid,
    output logic [DATA_W-1:0] ext_out,
    output logic              misalign,
    output logic [CNT_W-1:0]  err_cnt
);

    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
        $fatal(1, "m_ext_stage: DATA_W must be 32 or 64");
    end
    if (2 * IMM_W > DATA_W) begin : g_bad_imm_w
        $fatal(1, "m_ext_stage: 2*IMM_W must not exceed DATA_W");
    end
    if ((1 << LANE_W) != DATA_W / 8) begin : g_bad_lane_w
        $fatal(1, "m_ext_stage: LANE_W must equal log2(DATA_W/8)");
    end

    localparam logic [2:0] OpSign   = 3'b000;
    localparam logic [2:0] OpZero   = 3'b001;
    localparam logic [2:0] OpLui    = 3'b010;
    localparam logic [2:0] OpByteS  = 3'b011;
    localparam logic [2:0] OpByteZ  = 3'b100;
    localparam logic [2:0] OpHalfS  = 3'b101;
    localparam logic [2:0] OpHalfZ  = 3'b110;
    localparam logic [2:0] OpPass   = 3'b111;

    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] lane_word;
    logic [7:0]        lane_byte;
    logic [15:0]       lane_half;
    logic [DATA_W-1:0] calc;
    logic              calc_mis;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] ext_out_q, ext_out_d;
    logic              misalign_q, misalign_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

    assign imm       = ext_in[IMM_W-1:0];
    // Shift the addressed lane down to bit 0; byte/half are then the low bits.
    assign lane_word = ext_in >> {addr_lo, 3'b000};
    assign lane_byte = lane_word[7:0];
    assign lane_half = lane_word[15:0];

    always_comb begin
        calc     = '0;
        calc_mis = 1'b0;
        case (ext_op)
            OpSign:  calc = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
            OpZero:  calc = {{(DATA_W-IMM_W){1'b0}}, imm};
            OpLui:   calc = {imm, {(DATA_W-IMM_W){1'b0}}};
            OpByteS: calc = {{(DATA_W-8){lane_byte[7]}}, lane_byte};
            OpByteZ: calc = {{(DATA_W-8){1'b0}}, lane_byte};
            OpHalfS, OpHalfZ: begin
                // Odd lanes are misaligned; this also covers the top lane, the only
                // place a half could cross the word boundary.
                if (addr_lo[0]) begin
                    calc_mis = 1'b1;
                end else if (ext_op == OpHalfS) begin
                    calc = {{(DATA_W-16){lane_half[15]}}, lane_half};
                end else begin
                    calc = {{(DATA_W-16){1'b0}}, lane_half};
                end
            end
            OpPass:  calc = ext_in;
            default: calc = '0;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        ext_out_d   = ext_out_q;
        misalign_d  = misalign_q;
        err_cnt_d   = err_cnt_q;
        if (flush) begin
            out_valid_d = 1'b0;
            ext_out_d   = '0;
            misalign_d  = 1'b0;
        end else if (!stall) begin
            out_valid_d = in_valid;
            ext_out_d   = in_valid ? calc : '0;
            misalign_d  = in_valid & calc_mis;
            if (in_valid && calc_mis && (err_cnt_q != {CNT_W{1'b1}})) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            ext_out_q   <= '0;
            misalign_q  <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            ext_out_q   <= ext_out_d;
            misalign_q  <= misalign_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign ext_out   = ext_out_q;
    assign misalign  = misalign_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_m_ext_stage.sv
// Testbench for m_ext_stage: a 32-bit instance (CNT_W=2) and a 64-bit instance share
// stimulus; both are compared every cycle against a behavioural model, plus directed
// literal checks on key cases.
module tb_m_ext_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        stall;
    logic        flush;
    logic [2:0]  ext_op;
    logic [63:0] ext_in;
    logic [2:0]  addr_lo;

    logic        v32, m32, v64, m64;
    logic [31:0] o32;
    logic [63:0] o64;
    logic [1:0]  c32;
    logic [7:0]  c64;

    int n_checks = 0;
    int n_errors = 0;

    // Model state, index 0 = 32-bit instance, 1 = 64-bit instance.
    bit          e_v[2];
    logic [63:0] e_o[2];
    bit          e_m[2];
    int          e_c[2];
    int          c_max[2] = '{3, 255};
    int          width[2] = '{32, 64};

    m_ext_stage #(.DATA_W(32), .IMM_W(16), .LANE_W(2), .CNT_W(2)) u_dut32 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .stall     (stall),
        .flush     (flush),
        .ext_op    (ext_op),
        .ext_in    (ext_in[31:0]),
        .addr_lo   (addr_lo[1:0]),
        .out_valid (v32),
        .ext_out   (o32),
        .misalign  (m32),
        .err_cnt   (c32)
    );

    m_ext_stage #(.DATA_W(64), .IMM_W(16), .LANE_W(3), .CNT_W(8)) u_dut64 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .stall     (stall),
        .flush     (flush),
        .ext_op    (ext_op),
        .ext_in    (ext_in),
        .addr_lo   (addr_lo),
        .out_valid (v64),
        .ext_out   (o64),
        .misalign  (m64),
        .err_cnt   (c64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference result from the mode table, using plain integer arithmetic.
    function automatic longint unsigned ref_ext(input int w, input logic [2:0] op,
                                                input logic [63:0] din, input int a,
                                                output bit mis);
        longint unsigned mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
        longint unsigned word = din & mask;
        longint unsigned imm  = word & 64'hFFFF;
        int              lane = a % (w / 8);
        longint unsigned b    = (word >> (8 * lane)) & 64'hFF;
        longint unsigned h    = (word >> (8 * lane)) & 64'hFFFF;
        longint unsigned r    = 0;
        mis = 1'b0;
        case (op)
            3'd0: r = (imm >= 32768) ? imm - 65536 : imm;
            3'd1: r = imm;
            3'd2: r = imm << (w - 16);
            3'd3: r = (b >= 128) ? b - 256 : b;
            3'd4: r = b;
            3'd5, 3'd6: begin
                if ((lane % 2 == 1) || (lane + 2 > w / 8)) begin
                    mis = 1'b1;
                    r   = 0;
                end else if (op == 3'd5) begin
                    r = (h >= 32768) ? h - 65536 : h;
                end else begin
                    r = h;
                end
            end
            default: r = word;
        endcase
        return r & mask;
    endfunction

    // Advance one clock: update the model from current inputs, then compare both DUTs.
    task automatic step();
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                e_v[i] = 0; e_o[i] = '0; e_m[i] = 0; e_c[i] = 0;
            end else if (flush) begin
                e_v[i] = 0; e_o[i] = '0; e_m[i] = 0;
            end else if (!stall) begin
                e_v[i] = in_valid;
                if (in_valid) begin
                    bit mis;
                    e_o[i] = ref_ext(width[i], ext_op, ext_in, int'(addr_lo), mis);
                    e_m[i] = mis;
                    if (mis && e_c[i] < c_max[i]) e_c[i]++;
                end else begin
                    e_o[i] = '0; e_m[i] = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        check("v32", {63'd0, v32}, {63'd0, e_v[0]});
        check("o32", {32'd0, o32}, e_o[0]);
        check("m32", {63'd0, m32}, {63'd0, e_m[0]});
        check("c32", {62'd0, c32}, 64'(e_c[0]));
        check("v64", {63'd0, v64}, {63'd0, e_v[1]});
        check("o64", o64, e_o[1]);
        check("m64", {63'd0, m64}, {63'd0, e_m[1]});
        check("c64", {56'd0, c64}, 64'(e_c[1]));
    endtask

    task automatic drive(input bit v, input logic [2:0] op, input logic [63:0] din,
                         input logic [2:0] a);
        reset = 0; stall = 0; flush = 0;
        in_valid = v; ext_op = op; ext_in = din; addr_lo = a;
    endtask

    initial begin
        logic [31:0] bw;
        logic [31:0] byte_exp [4];
        bw = 32'h80F1_7F22;
        byte_exp = '{32'h0000_0022, 32'h0000_007F, 32'hFFFF_FFF1, 32'hFFFF_FF80};

        reset = 1; in_valid = 1; stall = 0; flush = 0;
        ext_op = 3'b101; ext_in = 64'h1; addr_lo = 3'd1;
        step();
        step();
        check("rst_valid", {63'd0, v32}, 64'd0);
        check("rst_out", {32'd0, o32}, 64'd0);
        check("rst_cnt", {62'd0, c32}, 64'd0);

        // Immediate modes.
        drive(1, 3'b000, 64'h0000_8001, 3'd1); step();
        check("imm_sign", {32'd0, o32}, 64'hFFFF_8001);
        check("imm_valid", {63'd0, v32}, 64'd1);
        check("imm_mis", {63'd0, m32}, 64'd0);
        drive(1, 3'b001, 64'h0000_8001, 3'd3); step();
        check("imm_zero", {32'd0, o32}, 64'h0000_8001);
        drive(1, 3'b010, 64'h0000_8001, 3'd0); step();
        check("imm_lui", {32'd0, o32}, 64'h8001_0000);

        // Byte lanes.
        for (int a = 0; a < 4; a++) begin
            drive(1, 3'b011, {32'd0, bw}, 3'(a)); step();
            check("byte_sign", {32'd0, o32}, {32'd0, byte_exp[a]});
        end
        drive(1, 3'b100, {32'd0, bw}, 3'd3); step();
        check("byte_zero", {32'd0, o32}, 64'h0000_0080);

        // Halfword alignment.
        drive(1, 3'b101, {32'd0, bw}, 3'd2); step();
        check("half_sign", {32'd0, o32}, 64'hFFFF_80F1);
        drive(1, 3'b110, {32'd0, bw}, 3'd0); step();
        check("half_zero", {32'd0, o32}, 64'h0000_7F22);
        drive(1, 3'b101, {32'd0, bw}, 3'd1); step();
        check("half_mis_out", {32'd0, o32}, 64'd0);
        check("half_mis_flag", {63'd0, m32}, 64'd1);
        check("half_mis_cnt", {62'd0, c32}, 64'd1);

        // Stall holds, flush beats stall.
        drive(1, 3'b001, 64'h1234, 3'd0); step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 3'(i), 64'($urandom), 3'($urandom_range(7)));
            stall = 1; step();
            check("stall_out", {32'd0, o32}, 64'h0000_1234);
            check("stall_valid", {63'd0, v32}, 64'd1);
        end
        stall = 1; flush = 1; step();
        check("flush_valid", {63'd0, v32}, 64'd0);
        check("flush_out", {32'd0, o32}, 64'd0);

        // Counter saturation on the CNT_W=2 instance.
        reset = 1; step();
        for (int i = 0; i < 5; i++) begin
            drive(1, 3'b110, 64'($urandom), 3'd3); step();
            check("sat_cnt", {62'd0, c32}, (i < 3) ? 64'(i + 1) : 64'd3);
        end
        flush = 1; step();
        check("sat_flush", {62'd0, c32}, 64'd3);

        // Reset mid-operation with a misaligned request present.
        drive(1, 3'b101, 64'($urandom), 3'd1); reset = 1; step();
        check("rst_mid_valid", {63'd0, v32}, 64'd0);
        check("rst_mid_mis", {63'd0, m32}, 64'd0);
        check("rst_mid_cnt", {62'd0, c32}, 64'd0);

        // 64-bit halfword at lane 6, and lane 7 misaligned.
        drive(1, 3'b101, 64'h8000_1111_2222_3333, 3'd6); step();
        check("w64_half", o64, 64'hFFFF_FFFF_FFFF_8000);
        drive(1, 3'b110, 64'h8000_1111_2222_3333, 3'd7); step();
        check("w64_lane7", {63'd0, m64}, 64'd1);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(99) == 0);
            flush    = ($urandom_range(9) == 0);
            stall    = ($urandom_range(4) == 0);
            in_valid = ($urandom_range(3) != 0);
            ext_op   = 3'($urandom_range(7));
            ext_in   = {$urandom, $urandom};
            addr_lo  = 3'($urandom_range(7));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
